// File: rtl/kt_pkg.sv
// Shared opcode, state and response constants for the KnightsTour command path.
package kt_pkg;

  typedef enum logic [3:0] {
    OP_CAL     = 4'h2,
    OP_MOVE    = 4'h4,
    OP_MOVE_FF = 4'h5,
    OP_TOUR_GO = 4'h6
  } opcode_t;

  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t CAL       = 3'd1;
  localparam state_t TURN      = 3'd2;
  localparam state_t RAMP_UP   = 3'd3;
  localparam state_t RAMP_DOWN = 3'd4;
  localparam state_t DONE      = 3'd5;

  localparam logic [7:0] RESP_ACK = 8'hA5;

  // Magnitude of a 12-bit two's complement value; 12'h800 maps to itself,
  // which still reads as a large unsigned magnitude.
  function automatic logic [11:0] abs12(input logic [11:0] v);
    return v[11] ? -v : v;
  endfunction

endpackage

// File: rtl/ir_rise_det.sv
// Single-flop rising-edge detector for an active-high IR line sensor.
module ir_rise_det (
  input  logic clk,
  input  logic rst,
  input  logic ir,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= ir;
  end

  assign rise = ir & ~prev;

endmodule

// File: rtl/cmd_proc.sv
// Command processor: decodes RemoteComm commands and sequences gyro calibration,
// heading turns and forward-speed ramps, counting board lines with the centre IR.
module cmd_proc
  import kt_pkg::*;
#(
  parameter bit          FAST_SIM   = 1'b1,
  parameter logic [9:0]  MAX_FRWRD  = 10'h2A0,
  parameter logic [11:0] ERR_THRESH = 12'h030,
  parameter logic [11:0] NUDGE      = 12'h05F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  output logic        send_resp,
  output logic        strt_cal,
  input  logic        cal_done,
  input  logic [11:0] heading,
  input  logic        heading_rdy,
  input  logic        lftIR,
  input  logic        cntrIR,
  input  logic        rghtIR,
  output logic        moving,
  output logic        en_fusion,
  output logic [9:0]  frwrd,
  output logic [11:0] error,
  output logic        fanfare_go,
  output logic        tour_go
);

  localparam logic [7:0] STEP    = FAST_SIM ? 8'h20 : 8'h03;
  localparam logic [9:0] DN_STEP = {1'b0, STEP, 1'b0};

  state_t      state;
  logic [3:0]  op;
  logic [11:0] desired_heading;
  logic [11:0] heading_d;
  logic [11:0] nudge;
  logic [11:0] raw_error;
  logic [4:0]  target;
  logic [4:0]  sq_cnt;
  logic [4:0]  sq_cnt_nxt;
  logic        cal_resp;
  logic        cntr_rise;
  logic        err_ok;
  logic [10:0] up_sum;
  logic [9:0]  up_val;
  logic [9:0]  dn_val;

  ir_rise_det u_cntr_det (
    .clk  (clk),
    .rst  (rst),
    .ir   (cntrIR),
    .rise (cntr_rise)
  );

  // A left-rail hit pushes the error positive, a right-rail hit negative;
  // both at once cancel out.
  always_comb begin
    nudge = 12'h000;
    if (lftIR && !rghtIR)      nudge = NUDGE;
    else if (rghtIR && !lftIR) nudge = -NUDGE;
  end

  assign raw_error  = heading_d - desired_heading + nudge;
  assign err_ok     = abs12(raw_error) < ERR_THRESH;
  assign error      = (state == IDLE || state == CAL) ? 12'h000 : raw_error;

  assign up_sum     = {1'b0, frwrd} + {3'b000, STEP};
  assign up_val     = (up_sum > {1'b0, MAX_FRWRD}) ? MAX_FRWRD : up_sum[9:0];
  assign dn_val     = (frwrd > DN_STEP) ? frwrd - DN_STEP : 10'h000;
  assign sq_cnt_nxt = sq_cnt + {4'b0000, cntr_rise};

  assign moving     = (state == TURN) || (state == RAMP_UP) || (state == RAMP_DOWN);
  assign en_fusion  = frwrd > {1'b0, MAX_FRWRD[9:1]};
  assign send_resp  = cal_resp || (state == DONE);
  assign fanfare_go = (state == DONE) && (op == OP_MOVE_FF);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      op              <= 4'h0;
      desired_heading <= 12'h000;
      heading_d       <= 12'h000;
      target          <= 5'd0;
      sq_cnt          <= 5'd0;
      frwrd           <= 10'h000;
      clr_cmd_rdy     <= 1'b0;
      strt_cal        <= 1'b0;
      tour_go         <= 1'b0;
      cal_resp        <= 1'b0;
    end else begin
      clr_cmd_rdy <= 1'b0;
      strt_cal    <= 1'b0;
      tour_go     <= 1'b0;
      cal_resp    <= 1'b0;
      heading_d   <= heading;

      case (state)
        // The clr_cmd_rdy guard stops a still-high cmd_rdy from being taken twice.
        IDLE: begin
          if (cmd_rdy && !clr_cmd_rdy) begin
            clr_cmd_rdy <= 1'b1;
            op          <= cmd[15:12];
            case (cmd[15:12])
              OP_CAL: begin
                state    <= CAL;
                strt_cal <= 1'b1;
              end
              OP_MOVE, OP_MOVE_FF: begin
                state           <= TURN;
                desired_heading <= (cmd[11:4] == 8'h00) ? 12'h000 : {cmd[11:4], 4'hF};
                target          <= {cmd[3:0], 1'b0};
                sq_cnt          <= 5'd0;
              end
              OP_TOUR_GO: tour_go <= 1'b1;
              default: ;
            endcase
          end
        end
        CAL: begin
          if (cal_done) begin
            cal_resp <= 1'b1;
            state    <= IDLE;
          end
        end
        TURN: begin
          if (heading_rdy && err_ok)
            state <= (target == 5'd0) ? DONE : RAMP_UP;
        end
        RAMP_UP: begin
          if (heading_rdy) frwrd <= up_val;
          sq_cnt <= sq_cnt_nxt;
          if (sq_cnt_nxt == target) state <= RAMP_DOWN;
        end
        RAMP_DOWN: begin
          if (heading_rdy) frwrd <= dn_val;
          if (frwrd == 10'h000) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
